// File: rtl/secure_debug_trace_if.sv
// Bundled functional and debug-port signals for secure_debug_trace.
// The master side drives data, capture and debug requests; the slave side is the trace block.
interface secure_debug_trace_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned KEY_W  = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              capture_en;
    logic              dbg_key_valid;
    logic [KEY_W-1:0]  dbg_key;
    logic              dbg_relock;
    logic              dbg_rd_req;
    logic              dbg_rd_valid;
    logic [DATA_W-1:0] dbg_rd_data;
    logic [CNT_W-1:0]  dbg_count;
    logic              dbg_unlocked;
    logic              dbg_lockout;

    modport master (
        output data_in, capture_en, dbg_key_valid, dbg_key, dbg_relock, dbg_rd_req,
        input  data_out, dbg_rd_valid, dbg_rd_data, dbg_count, dbg_unlocked, dbg_lockout
    );

    modport slave (
        input  data_in, capture_en, dbg_key_valid, dbg_key, dbg_relock, dbg_rd_req,
        output data_out, dbg_rd_valid, dbg_rd_data, dbg_count, dbg_unlocked, dbg_lockout
    );
endinterface

// File: rtl/secure_debug_trace.sv
// Key-gated trace buffer: captures data while locked, exposes a frozen snapshot for popping
// once unlocked, and latches into permanent lockout after MAX_FAIL consecutive bad keys.
module secure_debug_trace #(
    parameter int unsigned      DATA_W     = 8,
    parameter int unsigned      DEPTH      = 8,
    parameter int unsigned      KEY_W      = 16,
    parameter logic [KEY_W-1:0] UNLOCK_KEY = 16'hA5C3,
    parameter int unsigned      MAX_FAIL   = 3
) (
    input logic                 clk,
    input logic                 rst,
    secure_debug_trace_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [1:0] {StLocked, StUnlocked, StLockout} state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FAIL_W-1:0]  fail_q, fail_d, fail_inc;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [DATA_W-1:0]  data_out_q;
    logic               unlocked, key_match, do_clear, do_capture, do_pop, full;

    assign key_match = (bus.dbg_key == UNLOCK_KEY);
    assign fail_inc  = fail_q + FAIL_W'(1);
    assign full      = (count_q == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) state_q <= StLocked;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLocked: begin
                if (bus.dbg_key_valid) begin
                    if (key_match)                        state_d = StUnlocked;
                    else if (fail_inc == FAIL_W'(MAX_FAIL)) state_d = StLockout;
                end
            end
            StUnlocked: if (bus.dbg_relock) state_d = StLocked;
            StLockout:  state_d = StLockout;
            default:    state_d = StLocked;
        endcase
    end

    always_comb begin
        unlocked         = (state_q == StUnlocked);
        bus.dbg_unlocked = unlocked;
        bus.dbg_lockout  = (state_q == StLockout);
        bus.dbg_count    = unlocked ? count_q : '0;
    end

    // Relock has priority over a same-cycle pop; capture never coexists with pop (state-gated).
    always_comb begin
        do_clear   = unlocked && bus.dbg_relock;
        do_capture = !unlocked && bus.capture_en;
        do_pop     = unlocked && bus.dbg_rd_req && !bus.dbg_relock && (count_q != '0);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        fail_d     = fail_q;
        if (do_clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            fail_d  = '0;
        end else if (do_capture) begin
            wptr_d = wptr_q + PTR_W'(1);
            if (full) rptr_d = rptr_q + PTR_W'(1);
            else      count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            rptr_d  = rptr_q + PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
        if (state_q == StLocked && bus.dbg_key_valid) begin
            fail_d = key_match ? '0 : fail_inc;
        end
        rd_valid_d = do_pop;
        rd_data_d  = do_pop ? mem[rptr_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || do_clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_capture) begin
            mem[wptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            fail_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            data_out_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            fail_q     <= fail_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            data_out_q <= bus.data_in;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.dbg_rd_valid = rd_valid_q;
    assign bus.dbg_rd_data  = rd_data_q;
endmodule

// File: tb/tb_secure_debug_trace.sv
// Directed bench for secure_debug_trace with DEPTH=4, MAX_FAIL=3 and hand-computed expectations.
module tb_secure_debug_trace;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    secure_debug_trace_if #(.DATA_W(8), .DEPTH(4), .KEY_W(16)) bus ();

    secure_debug_trace #(
        .DATA_W    (8),
        .DEPTH     (4),
        .KEY_W     (16),
        .UNLOCK_KEY(16'hA5C3),
        .MAX_FAIL  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.capture_en    = 1'b0;
        bus.dbg_key_valid = 1'b0;
        bus.dbg_key       = '0;
        bus.dbg_relock    = 1'b0;
        bus.dbg_rd_req    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic capture(input logic [7:0] d);
        bus.capture_en = 1'b1;
        bus.data_in    = d;
        step();
        bus.capture_en = 1'b0;
    endtask

    task automatic key(input logic [15:0] k);
        bus.dbg_key_valid = 1'b1;
        bus.dbg_key       = k;
        step();
        bus.dbg_key_valid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic v, input logic [7:0] d, input int cnt);
        bus.dbg_rd_req = 1'b1;
        step();
        bus.dbg_rd_req = 1'b0;
        chk({tag, "_valid"}, 32'(bus.dbg_rd_valid), 32'(v));
        chk({tag, "_data"}, 32'(bus.dbg_rd_data), 32'(d));
        chk({tag, "_count"}, 32'(bus.dbg_count), 32'(cnt));
    endtask

    initial begin
        bus.data_in = 8'h00;
        idle();
        do_reset();
        chk("rst_data_out", 32'(bus.data_out), 32'h0);
        chk("rst_valid", 32'(bus.dbg_rd_valid), 32'h0);
        chk("rst_rd_data", 32'(bus.dbg_rd_data), 32'h0);
        chk("rst_unlocked", 32'(bus.dbg_unlocked), 32'h0);
        chk("rst_lockout", 32'(bus.dbg_lockout), 32'h0);
        chk("rst_count", 32'(bus.dbg_count), 32'h0);

        bus.data_in = 8'h5A;
        step();
        chk("data_out_reg", 32'(bus.data_out), 32'h5A);

        // Basic capture then drain, including one pop past empty.
        capture(8'h11);
        capture(8'h22);
        capture(8'h33);
        chk("locked_count_hidden", 32'(bus.dbg_count), 32'h0);
        key(16'hA5C3);
        chk("unlock", 32'(bus.dbg_unlocked), 32'h1);
        chk("unlock_count", 32'(bus.dbg_count), 32'h3);
        pop("p1", 1'b1, 8'h11, 2);
        pop("p2", 1'b1, 8'h22, 1);
        pop("p3", 1'b1, 8'h33, 0);
        pop("p4_empty", 1'b0, 8'h00, 0);

        // Overwrite of oldest entries; capture ignored while unlocked.
        do_reset();
        for (int i = 1; i <= 6; i++) capture(8'(i));
        key(16'hA5C3);
        chk("ovf_count", 32'(bus.dbg_count), 32'h4);
        for (int i = 0; i < 3; i++) capture(8'hAA);
        chk("frozen_count", 32'(bus.dbg_count), 32'h4);
        pop("ov1", 1'b1, 8'h03, 3);
        pop("ov2", 1'b1, 8'h04, 2);
        pop("ov3", 1'b1, 8'h05, 1);
        pop("ov4", 1'b1, 8'h06, 0);

        // Lockout after three bad keys, sticky until reset.
        do_reset();
        capture(8'h9C);
        key(16'h0000);
        key(16'h1111);
        chk("two_bad_no_lockout", 32'(bus.dbg_lockout), 32'h0);
        key(16'h2222);
        chk("lockout", 32'(bus.dbg_lockout), 32'h1);
        key(16'hA5C3);
        chk("lockout_key_ignored", 32'(bus.dbg_unlocked), 32'h0);
        chk("lockout_held", 32'(bus.dbg_lockout), 32'h1);
        pop("lockout_pop", 1'b0, 8'h00, 0);
        do_reset();
        chk("lockout_rst", 32'(bus.dbg_lockout), 32'h0);
        chk("lockout_rst_unl", 32'(bus.dbg_unlocked), 32'h0);

        // Successful unlock clears the fail counter.
        key(16'h0000);
        key(16'h0000);
        key(16'hA5C3);
        chk("unlock_after_2bad", 32'(bus.dbg_unlocked), 32'h1);
        bus.dbg_relock = 1'b1;
        step();
        bus.dbg_relock = 1'b0;
        chk("relock", 32'(bus.dbg_unlocked), 32'h0);
        key(16'h0000);
        key(16'h0000);
        chk("fail_cleared", 32'(bus.dbg_lockout), 32'h0);
        key(16'h0000);
        chk("third_bad_locks", 32'(bus.dbg_lockout), 32'h1);

        // Relock beats a same-cycle pop and zeroizes the buffer.
        do_reset();
        capture(8'h44);
        capture(8'h55);
        key(16'hA5C3);
        chk("two_entries", 32'(bus.dbg_count), 32'h2);
        bus.dbg_relock = 1'b1;
        bus.dbg_rd_req = 1'b1;
        step();
        idle();
        chk("relock_pop_valid", 32'(bus.dbg_rd_valid), 32'h0);
        chk("relock_pop_data", 32'(bus.dbg_rd_data), 32'h0);
        chk("relock_state", 32'(bus.dbg_unlocked), 32'h0);
        key(16'hA5C3);
        chk("relock_count0", 32'(bus.dbg_count), 32'h0);
        pop("after_relock", 1'b0, 8'h00, 0);

        // Reset in the middle of a pop stream.
        do_reset();
        capture(8'h77);
        capture(8'h88);
        key(16'hA5C3);
        pop("pre_rst", 1'b1, 8'h77, 1);
        bus.dbg_rd_req = 1'b1;
        bus.data_in    = 8'h99;
        rst            = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk("midrd_valid", 32'(bus.dbg_rd_valid), 32'h0);
        chk("midrd_data", 32'(bus.dbg_rd_data), 32'h0);
        chk("midrd_unlocked", 32'(bus.dbg_unlocked), 32'h0);
        chk("midrd_data_out", 32'(bus.data_out), 32'h0);
        key(16'hA5C3);
        chk("midrd_count0", 32'(bus.dbg_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/secure_debug_trace.md
SECURE_DEBUG_TRACE -- requirements
Module: secure_debug_trace

Interface
REQ-001 Parameter DATA_W, default 8: width of the data path and trace entries.
REQ-002 Parameter DEPTH, default 8: trace buffer entries, power of two, >=2.
REQ-003 Parameter KEY_W, default 16: width of the debug unlock key.
REQ-004 Parameter UNLOCK_KEY, default 16'hA5C3: the key value that unlocks the block.
REQ-005 Parameter MAX_FAIL, default 3: consecutive wrong keys that trigger permanent lockout, >=1.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 data_in  input  DATA_W  functional data.
REQ-009 data_out  output  DATA_W  data_in registered by one cycle.
REQ-010 capture_en  input  1  when high, data_in is written into the trace buffer this cycle.
REQ-011 dbg_key_valid  input  1  one-cycle strobe qualifying dbg_key.
REQ-012 dbg_key  input  KEY_W  unlock key attempt.
REQ-013 dbg_relock  input  1  returns UNLOCKED to LOCKED and zeroizes the buffer.
REQ-014 dbg_rd_req  input  1  pop request for the oldest trace entry.
REQ-015 dbg_rd_valid  output  1  dbg_rd_data holds a popped entry this cycle.
REQ-016 dbg_rd_data  output  DATA_W  popped entry; all zeros whenever dbg_rd_valid=0.
REQ-017 dbg_count  output  $clog2(DEPTH)+1  stored entries; reads 0 unless UNLOCKED.
REQ-018 dbg_unlocked  output  1  high in state UNLOCKED.
REQ-019 dbg_lockout  output  1  high in state LOCKOUT.

Function
REQ-020 data_out shall equal data_in from the previous cycle in every state.
REQ-021 The FSM shall have three states: LOCKED (reset state), UNLOCKED and LOCKOUT.
REQ-022 In LOCKED, a dbg_key_valid with dbg_key==UNLOCK_KEY shall move to UNLOCKED next cycle and clear the fail counter.
REQ-023 In LOCKED, a dbg_key_valid with a mismatching key shall increment the fail counter; on reaching MAX_FAIL the next state shall be LOCKOUT.
REQ-024 LOCKOUT shall be left only by rst; dbg_key_valid, dbg_relock and dbg_rd_req shall be ignored there.
REQ-025 dbg_key_valid in UNLOCKED and dbg_relock in LOCKED shall be ignored.
REQ-026 dbg_relock in UNLOCKED shall, next cycle, enter LOCKED, set the entry count to 0, reset pointers, zero every buffer entry and clear the fail counter.
REQ-027 Capture shall occur only in LOCKED and LOCKOUT; in UNLOCKED the buffer is a frozen snapshot and capture_en is ignored.
REQ-028 A capture shall write data_in at the write pointer; when not full the count shall increment; when full the oldest entry shall be overwritten, the read pointer advanced and the count held at DEPTH.
REQ-029 Pointers shall wrap modulo DEPTH.
REQ-030 dbg_rd_req in UNLOCKED with count>0 shall, next cycle, assert dbg_rd_valid with the oldest entry, advance the read pointer and decrement the count.
REQ-031 dbg_rd_req with count==0 or outside UNLOCKED shall yield dbg_rd_valid=0 and dbg_rd_data=0 next cycle.
REQ-032 dbg_rd_req and dbg_relock in the same UNLOCKED cycle: relock wins, no pop and dbg_rd_valid=0 next cycle.
REQ-033 Buffer contents shall never reach dbg_rd_data except through REQ-030.

Reset
REQ-034 On rst: state LOCKED, fail counter 0, pointers 0, count 0, all buffer entries 0, data_out=0, dbg_rd_valid=0, dbg_rd_data=0, dbg_unlocked=0, dbg_lockout=0.
REQ-035 rst shall override every other input in the same cycle, including mid-read and in LOCKOUT.

Verification (DATA_W=8, DEPTH=4, KEY_W=16, UNLOCK_KEY=16'hA5C3, MAX_FAIL=3)
REQ-036 Capture 11,22,33 locked; key A5C3; pop x4 -> rd_data 11,22,33 with valid, then valid=0 and data 00; count 3,2,1,0.
REQ-037 Capture 01..06 locked; unlock; pop x4 -> 03,04,05,06 (overwrite of oldest).
REQ-038 Keys 0000,1111,2222 -> dbg_lockout=1; then key A5C3 and pop -> still locked, rd_valid=0; rst -> LOCKED, lockout=0.
REQ-039 Keys 0000,0000 then A5C3 -> unlocked; relock; keys 0000 x2 -> still LOCKED (fail counter was cleared).
REQ-040 Unlock with 2 entries; relock with rd_req in same cycle -> rd_valid=0, count 0; re-unlock, pop -> rd_valid=0, data 00.
REQ-041 Unlocked, capture_en=1 with data AA for 3 cycles -> count unchanged; rst during pop -> next-cycle rd_valid=0, all outputs per REQ-034.
